// File: rtl/iso16_true_delivery_if.sv
// Sample stream into the delivery core: one warp/error beat per in_valid/in_ready handshake.
interface iso16_true_delivery_if #(
    parameter int WARP_WIDTH   = 16,
    parameter int ERR_IN_WIDTH = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [WARP_WIDTH-1:0] in_warp_x;
    logic signed [WARP_WIDTH-1:0] in_warp_y;
    logic signed [WARP_WIDTH-1:0] in_warp_z;
    logic [ERR_IN_WIDTH-1:0]      in_err;
    logic                         in_last;

    modport master (
        output in_valid, in_warp_x, in_warp_y, in_warp_z, in_err, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_warp_x, in_warp_y, in_warp_z, in_err, in_last,
        output in_ready
    );
endinterface

// File: rtl/iso16_true_delivery_core.sv
// Accumulates a frame of warp/error beats, checks warp symmetry and error budget,
// and on a true delivery requests a seal from an external engine and captures it.
module iso16_true_delivery_core #(
    parameter int WARP_WIDTH   = 16,
    parameter int ERROR_WIDTH  = 32,
    parameter int ERR_IN_WIDTH = 16,
    parameter int SYM_TOL      = 0,
    parameter int ERR_LIMIT    = 1000,
    parameter int SEAL_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    iso16_true_delivery_if.slave         beat,
    output logic [2:0]                   state,
    output logic signed [WARP_WIDTH-1:0] warp_sum_x,
    output logic signed [WARP_WIDTH-1:0] warp_sum_y,
    output logic signed [WARP_WIDTH-1:0] warp_sum_z,
    output logic [ERROR_WIDTH-1:0]       error_sum,
    output logic                         symmetry_ok,
    output logic                         error_ok,
    output logic                         true_delivery,
    output logic                         seal_start,
    input  logic                         seal_ready,
    input  logic [255:0]                 seal_in,
    output logic [255:0]                 seal,
    output logic                         done,
    output logic                         fail
);
    localparam int TW = $clog2(SEAL_TIMEOUT + 1);
    localparam logic [WARP_WIDTH:0]    TOL_W = (WARP_WIDTH + 1)'(SYM_TOL);
    localparam logic [ERROR_WIDTH-1:0] LIM_E = ERROR_WIDTH'(ERR_LIMIT);
    localparam logic [TW-1:0]          TMO_LAST = TW'(SEAL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCUM     = 3'd1,
        REDUCE    = 3'd2,
        EVAL      = 3'd3,
        CHECK     = 3'd4,
        SEAL_WAIT = 3'd5,
        DONE      = 3'd6,
        FAIL      = 3'd7
    } state_t;

    state_t                st;
    logic [WARP_WIDTH:0]   abs_x, abs_y, abs_z;
    logic [TW-1:0]         tmo_cnt;
    logic [ERR_IN_WIDTH-1:0] err_in;
    logic [ERROR_WIDTH:0]  err_next;
    logic                  sym_pass, err_pass;

    // One extra bit so the most negative sum has an exact magnitude.
    function automatic logic [WARP_WIDTH:0] abs_w(input logic [WARP_WIDTH-1:0] v);
        logic [WARP_WIDTH:0] e;
        e = {v[WARP_WIDTH-1], v};
        return e[WARP_WIDTH] ? -e : e;
    endfunction

    assign state         = st;
    assign beat.in_ready = (st == ACCUM);
    assign done          = (st == DONE);
    assign fail          = (st == FAIL);
    assign err_in        = beat.in_err;

    always_comb begin
        err_next = {1'b0, error_sum} + (ERROR_WIDTH + 1)'(err_in);
        sym_pass = (abs_x <= TOL_W) && (abs_y <= TOL_W) && (abs_z <= TOL_W);
        err_pass = (error_sum <= LIM_E);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= IDLE;
            warp_sum_x    <= '0;
            warp_sum_y    <= '0;
            warp_sum_z    <= '0;
            error_sum     <= '0;
            abs_x         <= '0;
            abs_y         <= '0;
            abs_z         <= '0;
            symmetry_ok   <= 1'b0;
            error_ok      <= 1'b0;
            true_delivery <= 1'b0;
            seal_start    <= 1'b0;
            seal          <= '0;
            tmo_cnt       <= '0;
        end else begin
            seal_start <= 1'b0;
            case (st)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        st            <= ACCUM;
                        warp_sum_x    <= '0;
                        warp_sum_y    <= '0;
                        warp_sum_z    <= '0;
                        error_sum     <= '0;
                        abs_x         <= '0;
                        abs_y         <= '0;
                        abs_z         <= '0;
                        symmetry_ok   <= 1'b0;
                        error_ok      <= 1'b0;
                        true_delivery <= 1'b0;
                        seal          <= '0;
                    end
                end
                ACCUM: begin
                    if (beat.in_valid) begin
                        warp_sum_x <= warp_sum_x + beat.in_warp_x;
                        warp_sum_y <= warp_sum_y + beat.in_warp_y;
                        warp_sum_z <= warp_sum_z + beat.in_warp_z;
                        error_sum  <= err_next[ERROR_WIDTH] ? '1 : err_next[ERROR_WIDTH-1:0];
                        if (beat.in_last) st <= REDUCE;
                    end
                end
                REDUCE: begin
                    abs_x <= abs_w(warp_sum_x);
                    abs_y <= abs_w(warp_sum_y);
                    abs_z <= abs_w(warp_sum_z);
                    st    <= EVAL;
                end
                EVAL: begin
                    symmetry_ok   <= sym_pass;
                    error_ok      <= err_pass;
                    true_delivery <= sym_pass && err_pass;
                    st            <= CHECK;
                end
                CHECK: begin
                    if (true_delivery) begin
                        st         <= SEAL_WAIT;
                        seal_start <= 1'b1;
                        tmo_cnt    <= '0;
                    end else begin
                        st <= FAIL;
                    end
                end
                SEAL_WAIT: begin
                    // tmo_cnt counts SEAL_WAIT cycles already spent without seal_ready.
                    if (seal_ready) begin
                        seal <= seal_in;
                        st   <= DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        st <= FAIL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iso16_true_delivery_core.sv
// Randomized bench for iso16_true_delivery_core: frames are scored against a
// frame-level model (plain sums, wrap by truncation, saturation by min).
module tb_iso16_true_delivery_core;
    localparam int W   = 16;
    localparam int EW  = 32;
    localparam int TOL = 0;
    localparam int LIM = 1000;
    localparam int TMO = 64;
    localparam int EW2 = 18;
    localparam logic [2:0] S_IDLE = 3'd0, S_ACCUM = 3'd1, S_REDUCE = 3'd2, S_EVAL = 3'd3,
                           S_CHECK = 3'd4, S_WAIT = 3'd5, S_DONE = 3'd6, S_FAIL = 3'd7;

    logic                clk = 1'b0;
    logic                rst, start, start2, seal_ready;
    logic [255:0]        seal_in, seal, s2_seal;
    logic [2:0]          state, s2_state;
    logic signed [W-1:0] warp_sum_x, warp_sum_y, warp_sum_z;
    logic signed [W-1:0] s2_sum_x, s2_sum_y, s2_sum_z;
    logic [EW-1:0]       error_sum;
    logic [EW2-1:0]      s2_error_sum;
    logic symmetry_ok, error_ok, true_delivery, seal_start, done, fail;
    logic s2_sym, s2_eok, s2_true, s2_seal_start, s2_done, s2_fail;

    iso16_true_delivery_if #(.WARP_WIDTH(W), .ERR_IN_WIDTH(16)) bus ();
    iso16_true_delivery_if #(.WARP_WIDTH(W), .ERR_IN_WIDTH(16)) bus2 ();

    always #5 clk = ~clk;

    iso16_true_delivery_core #(.WARP_WIDTH(W), .ERROR_WIDTH(EW), .ERR_IN_WIDTH(16),
        .SYM_TOL(TOL), .ERR_LIMIT(LIM), .SEAL_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .beat(bus), .state(state),
        .warp_sum_x(warp_sum_x), .warp_sum_y(warp_sum_y), .warp_sum_z(warp_sum_z),
        .error_sum(error_sum), .symmetry_ok(symmetry_ok), .error_ok(error_ok),
        .true_delivery(true_delivery), .seal_start(seal_start), .seal_ready(seal_ready),
        .seal_in(seal_in), .seal(seal), .done(done), .fail(fail));

    // Narrow error accumulator so saturation is reachable in a handful of beats.
    iso16_true_delivery_core #(.WARP_WIDTH(W), .ERROR_WIDTH(EW2), .ERR_IN_WIDTH(16),
        .SYM_TOL(TOL), .ERR_LIMIT(LIM), .SEAL_TIMEOUT(TMO)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .beat(bus2), .state(s2_state),
        .warp_sum_x(s2_sum_x), .warp_sum_y(s2_sum_y), .warp_sum_z(s2_sum_z),
        .error_sum(s2_error_sum), .symmetry_ok(s2_sym), .error_ok(s2_eok),
        .true_delivery(s2_true), .seal_start(s2_seal_start), .seal_ready(seal_ready),
        .seal_in(seal_in), .seal(s2_seal), .done(s2_done), .fail(s2_fail));

    int checks = 0;
    int failures = 0;
    int mx, my, mz;
    longint me;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return $signed(r);
    endfunction

    function automatic int absw(input int s);
        logic [W-1:0] t;
        int v;
        t = s[W-1:0];
        v = $signed(t);
        return (v < 0) ? -v : v;
    endfunction

    task automatic noise();
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_warp_x = 16'($urandom);
        bus.in_warp_y = 16'($urandom);
        bus.in_warp_z = 16'($urandom);
        bus.in_err    = 16'($urandom);
        bus.in_last   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b1;
        noise();
        step();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_state", state, S_IDLE);
        chk("rst_sumx", $unsigned(warp_sum_x), 0);
        chk("rst_sumy", $unsigned(warp_sum_y), 0);
        chk("rst_sumz", $unsigned(warp_sum_z), 0);
        chk("rst_err", error_sum, 0);
        chk("rst_flags", {symmetry_ok, error_ok, true_delivery}, 0);
        chk("rst_seal", seal, 0);
        chk("rst_ctl", {seal_start, done, fail, bus.in_ready}, 0);
    endtask

    task automatic start_frame();
        bus.in_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_state", state, S_ACCUM);
        chk("start_sums", {$unsigned(warp_sum_x), $unsigned(warp_sum_y), $unsigned(warp_sum_z)}, 0);
        chk("start_err", error_sum, 0);
        chk("start_flags", {symmetry_ok, error_ok, true_delivery, done, fail}, 0);
        chk("start_seal", seal, 0);
        mx = 0; my = 0; mz = 0; me = 0;
    endtask

    task automatic send_beat(input int x, input int y, input int z, input int e, input bit last);
        if ($urandom_range(0, 2) == 0) begin
            noise();
            bus.in_valid = 1'b0;
            chk("gap_ready", bus.in_ready, 1);
            step();
        end
        bus.in_valid  = 1'b1;
        bus.in_warp_x = x[W-1:0];
        bus.in_warp_y = y[W-1:0];
        bus.in_warp_z = z[W-1:0];
        bus.in_err    = e[15:0];
        bus.in_last   = last;
        chk("beat_ready", bus.in_ready, 1);
        chk("beat_state", state, S_ACCUM);
        step();
        mx += x; my += y; mz += z; me += longint'(e);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic finish_frame(input int delay, input bit start_in_wait, input logic [255:0] sv);
        logic [W-1:0]  ex, ey, ez;
        logic [EW-1:0] ee;
        longint        emax;
        bit            esym, eok, etr, hit;
        emax = 64'h0000_0000_FFFF_FFFF;
        ex = mx[W-1:0]; ey = my[W-1:0]; ez = mz[W-1:0];
        ee = (me > emax) ? '1 : me[EW-1:0];
        esym = (absw(mx) <= TOL) && (absw(my) <= TOL) && (absw(mz) <= TOL);
        eok  = (ee <= LIM);
        etr  = esym && eok;
        chk("reduce_state", state, S_REDUCE);
        chk("reduce_ready", bus.in_ready, 0);
        noise(); step();
        chk("eval_state", state, S_EVAL);
        noise(); step();
        chk("check_state", state, S_CHECK);
        chk("check_sym", symmetry_ok, esym);
        chk("check_errok", error_ok, eok);
        chk("check_true", true_delivery, etr);
        chk("check_sums", {$unsigned(warp_sum_x), $unsigned(warp_sum_y), $unsigned(warp_sum_z)}, {ex, ey, ez});
        chk("check_err", error_sum, ee);
        noise(); step();
        if (!etr) begin
            chk("nseal_state", state, S_FAIL);
            chk("nseal_start", seal_start, 0);
            chk("nseal_status", {done, fail}, 2'b01);
        end else begin
            hit = 1'b0;
            for (int i = 0; i < TMO && !hit; i++) begin
                chk("wait_state", state, S_WAIT);
                chk("wait_seal_start", seal_start, (i == 0));
                seal_ready = (i == delay);
                seal_in = seal_ready ? sv : {8{$urandom}};
                start = start_in_wait && ($urandom_range(0, 1) == 1);
                noise();
                step();
                hit = seal_ready;
                seal_ready = 1'b0;
                start = 1'b0;
            end
            if (hit) begin
                chk("done_state", state, S_DONE);
                chk("done_seal", seal, sv);
                chk("done_status", {done, fail}, 2'b10);
            end else begin
                chk("tmo_state", state, S_FAIL);
                chk("tmo_seal", seal, 0);
                seal_ready = 1'b1;
                seal_in = sv;
                step();
                seal_ready = 1'b0;
                chk("late_state", state, S_FAIL);
                chk("late_seal", seal, 0);
            end
        end
        noise(); step();
        chk("hold_sums", {$unsigned(warp_sum_x), $unsigned(warp_sum_y), $unsigned(warp_sum_z)}, {ex, ey, ez});
        chk("hold_err", error_sum, ee);
        chk("hold_flags", {symmetry_ok, error_ok, true_delivery}, {esym, eok, etr});
        chk("hold_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic rand_frame();
        int nb, x, y, z, e, d;
        bit bal;
        nb  = $urandom_range(1, 4);
        bal = 1'($urandom_range(0, 1));
        start_frame();
        for (int b = 0; b < nb; b++) begin
            x = rnd16(); y = rnd16(); z = rnd16();
            e = $urandom_range(0, 300);
            if (bal && b == nb - 1) begin
                x = -mx; y = -my; z = -mz;
            end
            send_beat(x, y, z, e, (b == nb - 1));
        end
        d = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 5);
        finish_frame(d, 1'($urandom_range(0, 1)), {8{$urandom}});
    endtask

    task automatic sat_test();
        int     vals[7];
        longint acc, smax;
        vals = '{65535, 65535, 65535, 65535, 3, 1, 65535};
        smax = (64'd1 << EW2) - 1;
        acc = 0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("sat_start", s2_state, S_ACCUM);
        for (int i = 0; i < 7; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_err   = vals[i][15:0];
            bus2.in_last  = (i == 6);
            step();
            acc = (acc + vals[i] > smax) ? smax : acc + vals[i];
            chk("sat_sum", s2_error_sum, acc);
        end
        bus2.in_valid = 1'b0;
        step(); step();
        chk("sat_check_state", s2_state, S_CHECK);
        chk("sat_flags", {s2_sym, s2_eok, s2_true}, 3'b100);
        step();
        chk("sat_fail", {s2_state, s2_seal_start, s2_fail}, {S_FAIL, 2'b01});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; seal_ready = 1'b0; seal_in = '0;
        bus.in_valid = 1'b0; bus.in_warp_x = '0; bus.in_warp_y = '0; bus.in_warp_z = '0;
        bus.in_err = '0; bus.in_last = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_warp_x = '0; bus2.in_warp_y = '0; bus2.in_warp_z = '0;
        bus2.in_err = '0; bus2.in_last = 1'b0;
        step(); step();
        do_reset();
        repeat (3) begin
            noise(); step();
            chk("idle_state", state, S_IDLE);
            chk("idle_err", error_sum, 0);
        end
        bus.in_valid = 1'b0;

        start_frame();
        send_beat(3, -2, 5, 10, 0);
        send_beat(-3, 2, -5, 20, 1);
        finish_frame(0, 0, {32{8'hA5}});

        start_frame();
        send_beat(1, 0, 0, 0, 1);
        finish_frame(0, 0, {8{32'h1234_5678}});

        start_frame();
        send_beat(-32768, 0, 0, 0, 0);
        send_beat(-32768, 0, 0, 0, 1);
        finish_frame(2, 1, {8{32'hCAFE_F00D}});

        start_frame();
        send_beat(-32768, 0, 0, 0, 1);
        finish_frame(0, 0, '0);

        start_frame();
        send_beat(0, 0, 0, 1000, 1);
        finish_frame(1, 0, {8{32'h0BAD_BEEF}});

        start_frame();
        send_beat(0, 0, 0, 600, 0);
        send_beat(0, 0, 0, 401, 1);
        finish_frame(0, 0, '0);

        start_frame();
        send_beat(5, 5, 5, 7, 0);
        send_beat(-5, -5, -5, 7, 1);
        finish_frame(TMO, 1, {8{32'hDEAD_0001}});

        start_frame();
        send_beat(100, -7, 3, 9, 0);
        send_beat(11, 12, 13, 14, 0);
        do_reset();
        repeat (2) begin
            noise(); step();
            chk("post_rst_idle", state, S_IDLE);
        end
        start_frame();
        send_beat(0, 0, 0, 5, 1);
        finish_frame(3, 0, {8{32'h5555_AAAA}});

        repeat (25) rand_frame();

        sat_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
